// File: rtl/interface_jogada.sv
// Switch input stage for the game datapath: debounces chaves, waits for release,
// and reports each accepted press once as a valid (one-hot) or invalid play.
module interface_jogada #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int CW              = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] chaves,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic       tem_jogada,
  output logic [3:0] db_estado
);

  localparam logic [1:0] ESPERA   = 2'd0;
  localparam logic [1:0] FILTRA   = 2'd1;
  localparam logic [1:0] REGISTRA = 2'd2;
  localparam logic [1:0] SOLTAR   = 2'd3;

  localparam logic [CW-1:0] ULTIMO = CW'(DEBOUNCE_CICLOS - 1);

  logic [1:0]    estado;
  logic [3:0]    amostra;
  logic [CW-1:0] contador;

  function automatic logic onehot(input logic [3:0] x);
    logic r;
    case (x)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= ESPERA;
      amostra  <= '0;
      contador <= '0;
      jogada   <= '0;
    end else begin
      case (estado)
        ESPERA: begin
          if (habilita && (chaves != 4'b0000)) begin
            estado   <= FILTRA;
            amostra  <= chaves;
            contador <= '0;
          end
        end
        FILTRA: begin
          if (!habilita || (chaves == 4'b0000)) begin
            estado <= ESPERA;
          end else if (chaves != amostra) begin
            // a different key pattern restarts the stability window
            amostra  <= chaves;
            contador <= '0;
          end else if (contador == ULTIMO) begin
            estado <= REGISTRA;
            if (onehot(amostra)) jogada <= amostra;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        REGISTRA: begin
          estado   <= SOLTAR;
          contador <= '0;
        end
        SOLTAR: begin
          // any key still down (even a new one) only delays the release
          if (chaves != 4'b0000) begin
            contador <= '0;
          end else if (contador == ULTIMO) begin
            estado <= ESPERA;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        default: estado <= ESPERA;
      endcase
    end
  end

  assign jogada_feita    = (estado == REGISTRA) &&  onehot(amostra);
  assign jogada_invalida = (estado == REGISTRA) && !onehot(amostra);
  assign tem_jogada      = |chaves;
  assign db_estado       = {2'b00, estado};

endmodule
